// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: host read port of the buffered UART receiver.
// The host pops with rd; data, valid and occupancy come back from the FIFO.
interface uart_rx_fifo_if #(
    parameter int FIFO_DEPTH = 8
);
    logic                        rd;
    logic [7:0]                  rd_data;
    logic                        rd_valid;
    logic [$clog2(FIFO_DEPTH):0] count;

    modport master (
        output rd,
        input  rd_data,
        input  rd_valid,
        input  count
    );

    modport slave (
        input  rd,
        output rd_data,
        output rd_valid,
        output count
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 16x oversampled 8N1 receiver feeding a show-ahead FIFO.
// Framing errors and dropped bytes are reported as one-cycle pulses.
module uart_rx_fifo #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD_RATE  = 115200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          rx_enable,
    input  logic          rx,
    uart_rx_fifo_if.slave rd_port,
    output logic          busy,
    output logic          frame_err,
    output logic          overflow
);
    localparam int DIV = CLK_FREQ / (BAUD_RATE * 16);
    localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;
    localparam logic [TW-1:0] TICK_AT = TW'(DIV - 1);
    localparam logic [CW-1:0] FULL_AT = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE, START, DATA, STOP, BRK
    } state_t;

    state_t        state, state_n;
    logic          rx_s1, rx_s2, rx_d;
    logic          fall, run, tick, decide, wrap;
    logic [TW-1:0] tcnt;
    logic [3:0]    os;
    logic          s6, s7, bit_val;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          push_req, ferr_set, shift_en;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] cnt;
    logic          valid, full, pop, do_push;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_d  <= 1'b1;
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
            rx_d  <= rx_s2;
        end
    end

    assign fall    = rx_d & ~rx_s2;
    assign run     = rx_enable && (state != IDLE);
    assign tick    = run && (tcnt == TICK_AT);
    // samples land as os becomes 6 and 7; the vote fires as os becomes 8
    assign decide  = tick && (os == 4'd7);
    assign wrap    = tick && (os == 4'd15);
    assign bit_val = (s6 & s7) | (s6 & rx_s2) | (s7 & rx_s2);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tcnt <= '0;
            os   <= '0;
        end else if (!run) begin
            tcnt <= '0;
            os   <= '0;
        end else if (tick) begin
            tcnt <= '0;
            os   <= os + 4'd1;
        end else begin
            tcnt <= tcnt + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s6      <= 1'b1;
            s7      <= 1'b1;
            bit_cnt <= '0;
            shreg   <= '0;
        end else begin
            if (tick && os == 4'd5) s6 <= rx_s2;
            if (tick && os == 4'd6) s7 <= rx_s2;
            if (state != DATA) bit_cnt <= '0;
            else if (wrap) bit_cnt <= bit_cnt + 3'd1;
            if (shift_en) shreg <= {bit_val, shreg[7:1]};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= IDLE;
        else state <= state_n;
    end

    always_comb begin
        state_n  = state;
        push_req = 1'b0;
        ferr_set = 1'b0;
        shift_en = 1'b0;
        if (!rx_enable) begin
            state_n = IDLE;
        end else begin
            unique case (state)
                IDLE:  if (fall) state_n = START;
                START: begin
                    if (decide && bit_val) state_n = IDLE;
                    else if (wrap) state_n = DATA;
                end
                DATA: begin
                    shift_en = decide;
                    if (wrap && bit_cnt == 3'd7) state_n = STOP;
                end
                STOP: begin
                    if (decide) begin
                        push_req = bit_val;
                        ferr_set = ~bit_val;
                        state_n  = bit_val ? IDLE : BRK;
                    end
                end
                BRK:   if (rx_s2) state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
    end

    assign busy    = (state != IDLE);
    assign valid   = (cnt != '0);
    assign full    = (cnt == FULL_AT);
    assign pop     = rd_port.rd && valid;
    assign do_push = push_req && (!full || pop);

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= shreg;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt       <= '0;
            frame_err <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            cnt       <= cnt + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, pop};
            frame_err <= ferr_set;
            overflow  <= push_req && full && !pop;
        end
    end

    assign rd_port.rd_valid = valid;
    assign rd_port.rd_data  = valid ? mem[rd_ptr] : 8'h00;
    assign rd_port.count    = cnt;
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Buffered UART receiver: the receive-side counterpart to `uart_tx`. It takes the serial line `rx`, samples it at 16x oversampling with a majority vote, and checks framing on 8N1 frames. Good bytes go into a show-ahead receive FIFO that a host reads with a simple `rd` strobe. It sits beside `uart_tx` in the peripheral subsystem and is intended as the drop-in buffered replacement for `uart_rx` wherever the host cannot service every byte in time.

## Interface
- `CLK_FREQ`, 50000000, system clock frequency in Hz
- `BAUD_RATE`, 115200, line rate in bit/s
- `FIFO_DEPTH`, 8, receive FIFO entries; must be a power of 2, ≥2
- `clk_i`  input  1  system clock; the only clock
- `rst_ni`  input  1  asynchronous reset, active low
- `rx_enable`  input  1  receiver enable; when low the receiver is held idle and the FIFO is retained
- `rx`  input  1  serial line, idle high, asynchronous to `clk_i`
- `rd`  input  1  pop strobe; acts only while `rd_valid`=1
- `rd_data`  output  8  head of FIFO (show-ahead); 8'h00 when empty
- `rd_valid`  output  1  FIFO not empty
- `count`  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- `busy`  output  1  high while the FSM is outside IDLE
- `frame_err`  output  1  one-cycle pulse when a stop bit samples 0
- `overflow`  output  1  one-cycle pulse when a good byte is dropped because the FIFO is full

## Operation
- Synchronizer: `rx` passes through 2 flops, both reset to 1. All logic uses the synchronized value.
- Tick generator:
  - `DIV = CLK_FREQ/(BAUD_RATE*16)`, integer division (27 at the defaults).
  - The counter runs 0..DIV-1 and emits a tick at DIV-1.
  - It is cleared and held while `rx_enable`=0 or the FSM is in IDLE.
- Oversample counter `os` runs 0..15 and advances once per tick.
- Bit decision: made at `os`=8 as the majority of the samples taken at `os`=6, 7 and 8.
- FSM states and transitions:
  - IDLE → START on a synchronized 1→0 edge with `rx_enable`=1. Clears `os` and the tick counter.
  - START: a decision of 1 is a false start and returns to IDLE. A decision of 0 goes to DATA when `os` wraps 15→0.
  - DATA: takes 8 bits, LSB first, each decided at `os`=8 and shifted into a shift register. After bit 7, goes to STOP when `os` wraps.
  - STOP, decision 1: push the byte and go to IDLE in the same cycle. Returning at mid-stop allows back-to-back frames.
  - STOP, decision 0: pulse `frame_err`, discard the byte, go to BREAK.
  - BREAK → IDLE once synchronized `rx`=1.
- `rx_enable` falling: the FSM goes to IDLE on the next edge and any partial frame is discarded. `frame_err` and `overflow` do not fire for it.
- FIFO push/pop rules:
  - Push occurs at the STOP decision.
  - Pop occurs when `rd` && `rd_valid`; `rd` while empty is ignored.
  - Push and pop in the same cycle: both take effect, `count` is unchanged, and this holds even when full (no overflow).
  - Push while full without a pop: the byte is dropped, `overflow` pulses, and FIFO contents are unchanged.
- Pointers are $clog2(FIFO_DEPTH) bits and wrap naturally. `count` ranges 0..FIFO_DEPTH.

## Timing
- Reset values: `rd_data`=0, `rd_valid`=0, `count`=0, `busy`=0, `frame_err`=0, `overflow`=0; FSM in IDLE; synchronizer flops at 1.
- Reset asserted mid-frame or with data in the FIFO: all of the above are restored immediately, without waiting for a clock edge.
- Input latency: 2 clocks of synchronizer delay from `rx` to the FSM.
- Bit period is 16×DIV clocks (432 clocks = 8640 ns at the defaults, −0.46% against nominal). Tolerated total drift is about ±3%.
- Push latency: the STOP decision is at 9.5 bit periods plus 2–3 clocks after the start edge.
  - `rd_valid`, `rd_data` and `count` update on the clock edge after that decision.
  - `frame_err` and `overflow` are registered in that same cycle and last exactly one cycle.
- Pop: `rd` is sampled on an edge; `rd_data` shows the next entry (or 0 if empty) and `count` updates on that same edge.
- `busy` rises the clock after the start edge is detected and falls the clock after the IDLE transition.

## Test plan
- Single frame (50 MHz clock, 8680 ns/bit): send 0xA5 (LSB first) → `rd_valid`=1 with `rd_data`=0xA5 and `count`=1 about 9.5 bits after the start edge. A one-cycle `rd` → `count`=0, `rd_valid`=0, `rd_data`=0x00.
- Glitch rejection: hold `rx` low for 100 ns, then high → `busy` pulses and then returns to IDLE. No push, no `frame_err`. A following 0x5A frame is received correctly.
- Framing error: send 0x3C with stop=0 and hold `rx` low for 2 more bit periods → a single `frame_err` pulse, `count` stays 0, FSM in BREAK. After `rx` goes high, 0x55 is received as 0x55.
- Overflow and wrap:
  - Send 9 back-to-back frames 0x00..0x08 with no reads → `overflow` pulses once, on the 9th frame, and `count`=8.
  - 8 reads return 0x00..0x07.
  - A further 3 frames 0x10..0x12, read back → 0x10..0x12 (pointer wrap).
- Simultaneous push/pop when full: assert `rd` exactly in the push cycle of a 9th frame → no `overflow`, `count` stays 8, and the read order is preserved with the new byte last.
- Abort paths, each followed by a clean 0xC3 frame that must be received as 0xC3 with `count` reflecting only complete frames:
  - Drop `rx_enable` during data bit 3.
  - Assert `rst_ni` low for 30 ns mid-frame.
